// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider for the execute stage.
//   Handles DIV (signed) and DIVU (unsigned). Each cycle produces one
//   quotient bit, so a non-zero divide takes WIDTH+2 edges from the edge
//   that samples start_i to ready_o. A zero divisor finishes in two edges
//   and returns zero.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   signed_div_i 1 = signed divide, 0 = unsigned; sampled at start
//   opdata1_i    dividend; sampled at start
//   opdata2_i    divisor; sampled at start
//   start_i      request, held high until ready_o has been seen
//   annul_i      abort an in-flight divide (pipeline flush)
//   result_o     {remainder, quotient}; valid while ready_o = 1
//   ready_o      result valid
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    ST_FREE   = 2'd0,
    ST_BYZERO = 2'd1,
    ST_ON     = 2'd2,
    ST_END    = 2'd3
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  // Upper bits hold the not-yet-consumed dividend, lower bits collect
  // quotient bits as the dividend shifts out the top.
  logic [WIDTH-1:0]   dividend;
  logic [WIDTH-1:0]   divisor;
  logic [WIDTH-1:0]   rem;
  logic               sign1;
  logic               sign2;
  logic               signed_mode;

  // Shifted partial remainder is WIDTH+1 bits so the trial compare
  // cannot overflow when the divisor has its top bit set.
  logic [WIDTH:0]     shifted;
  logic [WIDTH-1:0]   diff;
  logic               fits;

  // Magnitude of a two's-complement value; the most negative value maps
  // onto itself, which is its correct unsigned magnitude.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic             sgn);
    return (sgn && v[WIDTH-1]) ? -v : v;
  endfunction

  function automatic logic [WIDTH-1:0] negate_if(input logic [WIDTH-1:0] v,
                                                 input logic             neg);
    return neg ? -v : v;
  endfunction

  always_comb begin
    shifted = {rem, dividend[WIDTH-1]};
    fits    = (shifted >= {1'b0, divisor});
    // Only used when fits, where the true difference is below 2^WIDTH.
    diff    = shifted[WIDTH-1:0] - divisor;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_FREE;
      cnt         <= '0;
      dividend    <= '0;
      divisor     <= '0;
      rem         <= '0;
      sign1       <= 1'b0;
      sign2       <= 1'b0;
      signed_mode <= 1'b0;
      ready_o     <= 1'b0;
      result_o    <= '0;
    end else begin
      case (state)
        ST_FREE: begin
          ready_o  <= 1'b0;
          result_o <= '0;
          if (start_i && !annul_i) begin
            if (opdata2_i == '0) begin
              state <= ST_BYZERO;
            end else begin
              state       <= ST_ON;
              cnt         <= '0;
              rem         <= '0;
              dividend    <= magnitude(opdata1_i, signed_div_i);
              divisor     <= magnitude(opdata2_i, signed_div_i);
              sign1       <= opdata1_i[WIDTH-1];
              sign2       <= opdata2_i[WIDTH-1];
              signed_mode <= signed_div_i;
            end
          end
        end

        ST_BYZERO: begin
          state    <= ST_END;
          result_o <= '0;
          ready_o  <= 1'b1;
        end

        ST_ON: begin
          if (annul_i) begin
            state    <= ST_FREE;
            ready_o  <= 1'b0;
            result_o <= '0;
            cnt      <= '0;
          end else if (cnt != CNT_W'(WIDTH)) begin
            rem      <= fits ? diff : shifted[WIDTH-1:0];
            dividend <= {dividend[WIDTH-2:0], fits};
            cnt      <= cnt + CNT_W'(1);
          end else begin
            // Remainder takes the dividend's sign; quotient is negative
            // when the operand signs differ.
            result_o <= {negate_if(rem,      signed_mode & sign1),
                         negate_if(dividend, signed_mode & (sign1 ^ sign2))};
            ready_o  <= 1'b1;
            state    <= ST_END;
          end
        end

        ST_END: begin
          if (!start_i) begin
            state    <= ST_FREE;
            ready_o  <= 1'b0;
            result_o <= '0;
          end
        end

        default: begin
          state    <= ST_FREE;
          ready_o  <= 1'b0;
          result_o <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed bench for div_unit. A vector table covers the
// arithmetic cases (latency, result, hold, clear); hand-written sequences
// cover annul, annul-in-END and asynchronous reset.
module tb_div_unit;

  logic        clk;
  logic        rst;
  logic        signed_div;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        start;
  logic        annul;
  logic [63:0] result;
  logic        ready;

  int total = 0;
  int bad   = 0;

  div_unit #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div),
    .opdata1_i    (op1),
    .opdata2_i    (op2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] res;   // {remainder, quotient}
    int          lat;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Counts edges from the sampling edge (edge 1) until ready_o is seen.
  task automatic wait_ready(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!ready && n < 60);
  endtask

  task automatic run_div(input string name, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp, input int lat);
    int n;
    @(negedge clk);
    signed_div = sgn;
    op1        = a;
    op2        = b;
    start      = 1'b1;
    wait_ready(n);
    chk({name, " latency"}, 64'(n), 64'(lat));
    chk({name, " result"}, result, exp);
    // Operands change while start stays high: result must hold.
    @(negedge clk);
    op1 = ~a;
    op2 = 32'd3;
    @(posedge clk);
    #1;
    chk({name, " hold"}, {ready, result[62:0]}, {1'b1, exp[62:0]});
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    chk({name, " clear"}, {63'd0, ready} | result, 64'd0);
  endtask

  initial begin
    int  n;
    logic seen;

    vecs[0]  = '{1'b0, 32'd100,        32'd7,          {32'd2,          32'd14},         34};
    vecs[1]  = '{1'b1, 32'hFFFFFFF9,   32'd2,          {32'hFFFFFFFF,   32'hFFFFFFFD},   34};
    vecs[2]  = '{1'b1, 32'd7,          32'hFFFFFFFE,   {32'd1,          32'hFFFFFFFD},   34};
    vecs[3]  = '{1'b0, 32'hFFFFFFFF,   32'd2,          {32'd1,          32'h7FFFFFFF},   34};
    vecs[4]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   {32'd0,          32'h80000000},   34};
    vecs[5]  = '{1'b0, 32'd5,          32'd0,          64'd0,                             2};
    vecs[6]  = '{1'b1, 32'hFFFFFFF9,   32'd0,          64'd0,                             2};
    vecs[7]  = '{1'b1, 32'hFFFFFF9C,   32'd7,          {32'hFFFFFFFE,   32'hFFFFFFF2},   34};
    vecs[8]  = '{1'b0, 32'd0,          32'd5,          64'd0,                            34};
    vecs[9]  = '{1'b0, 32'd7,          32'd9,          {32'd7,          32'd0},          34};
    vecs[10] = '{1'b1, 32'h80000000,   32'd2,          {32'd0,          32'hC0000000},   34};
    vecs[11] = '{1'b0, 32'h80000000,   32'hFFFFFFFF,   {32'h80000000,   32'd0},          34};

    rst        = 1'b0;
    signed_div = 1'b0;
    op1        = '0;
    op2        = '0;
    start      = 1'b0;
    annul      = 1'b0;
    #12;
    chk("reset ready", {63'd0, ready}, 64'd0);
    chk("reset result", result, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 12; i++)
      run_div($sformatf("vec%0d", i), vecs[i].sgn, vecs[i].a, vecs[i].b,
              vecs[i].res, vecs[i].lat);

    // Annul at cnt=10 (after edge 11); flush also drops start.
    @(negedge clk);
    signed_div = 1'b0;
    op1 = 32'd100;
    op2 = 32'd7;
    start = 1'b1;
    repeat (11) @(posedge clk);
    @(negedge clk);
    annul = 1'b1;
    start = 1'b0;
    @(posedge clk);
    #1;
    chk("annul ready", {63'd0, ready}, 64'd0);
    @(negedge clk);
    annul = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (ready) seen = 1'b1;
    end
    chk("annul never ready", {63'd0, seen}, 64'd0);
    run_div("after annul 9/3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 34);

    // annul_i is ignored once the result is ready.
    @(negedge clk);
    signed_div = 1'b0;
    op1 = 32'd7;
    op2 = 32'd9;
    start = 1'b1;
    wait_ready(n);
    chk("end latency", 64'(n), 64'd34);
    @(negedge clk);
    annul = 1'b1;
    @(posedge clk);
    #1;
    chk("annul in end", {ready, result[62:0]}, {1'b1, 63'h7_0000_0000});
    @(negedge clk);
    annul = 1'b0;
    start = 1'b0;
    @(posedge clk);
    #1;
    chk("end clear", {63'd0, ready} | result, 64'd0);

    // Asynchronous reset while a result is presented.
    @(negedge clk);
    op1 = 32'd100;
    op2 = 32'd7;
    start = 1'b1;
    wait_ready(n);
    chk("pre-reset result", result, {32'd2, 32'd14});
    #3;
    rst = 1'b0;
    #1;
    chk("async reset ready", {63'd0, ready}, 64'd0);
    chk("async reset result", result, 64'd0);
    @(negedge clk);
    start = 1'b0;
    rst = 1'b1;

    // Asynchronous reset mid-ON, then a full-latency restart.
    @(negedge clk);
    op1 = 32'd100;
    op2 = 32'd7;
    start = 1'b1;
    repeat (10) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("mid-on reset ready", {63'd0, ready}, 64'd0);
    chk("mid-on reset result", result, 64'd0);
    @(negedge clk);
    start = 1'b0;
    rst = 1'b1;
    run_div("after reset 100/7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 34);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected finish before 200000");
    $fatal(1);
  end

endmodule
